score_controller: RTL and testbench

- Game-level score sequencer that owns the score and max_score registers feeding the seven-segment display driver.
- Counts hit events during play, saturates at a configurable ceiling, and latches the high score at game over.
- Runs a game-state FSM (IDLE/PLAY/OVER) and produces a blink control so the display flashes the final score after game over.
- Sits between the game logic (hit/game_over/start) and the display block.

---
 rtl/score_controller.sv | 125 ++++++++++++
 tb/tb_score_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_controller.sv
// score_controller
//   Game-level score sequencer feeding the seven-segment display driver.
//   Counts hit rising edges during play with saturation at MAX_VAL, latches
//   the high score on game over, and drives a blink request for the score
//   digits while the game is over.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset, waiting for start; hit/game_over ignored
//   PLAY  | game running, hits add HIT_POINTS up to MAX_VAL
//   OVER  | final score shown blinking, waiting for start of next game
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   start       begins a new game when sampled high in IDLE or OVER
//   hit         level from game logic, each rising edge is one hit
//   game_over   ends the game when sampled high in PLAY
//   score       current score, 0..MAX_VAL
//   max_score   highest final score since reset
//   playing     high while in PLAY
//   score_blank blink blanking request for the score digits
//   new_record  high in OVER when the last game set a new max_score
module score_controller #(
   parameter int HIT_POINTS = 1,
   parameter int MAX_VAL    = 99,
   parameter int BLINK_BITS = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hit,
   input  logic       game_over,
   output logic [6:0] score,
   output logic [6:0] max_score,
   output logic       playing,
   output logic       score_blank,
   output logic       new_record
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [7:0] HIT8 = 8'(HIT_POINTS);
   localparam logic [6:0] MAX7 = 7'(MAX_VAL);

   state_t                state;
   logic                  hit_q;
   logic [BLINK_BITS-1:0] blink_cnt;

   logic                  hit_rise;
   logic [7:0]            sum;
   logic [6:0]            hit_score;
   logic [6:0]            final_score;

   // Sum is formed in 8 bits so 99 + HIT_POINTS cannot wrap before clamping.
   always_comb begin
      hit_rise    = hit & ~hit_q;
      sum         = {1'b0, score} + HIT8;
      hit_score   = (sum > {1'b0, MAX7}) ? MAX7 : sum[6:0];
      final_score = hit_rise ? hit_score : score;
   end

   // Counter is held at zero outside OVER, so its MSB is the blink request
   // directly and is guaranteed low whenever the game is not over.
   assign score_blank = blink_cnt[BLINK_BITS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         score      <= '0;
         max_score  <= '0;
         playing    <= 1'b0;
         new_record <= 1'b0;
         blink_cnt  <= '0;
         // A hit held high through reset must not count as an edge.
         hit_q      <= 1'b1;
      end else begin
         hit_q <= hit;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_PLAY;
                  score      <= '0;
                  new_record <= 1'b0;
                  playing    <= 1'b1;
               end
            end
            S_PLAY: begin
               score <= final_score;
               if (game_over) begin
                  state   <= S_OVER;
                  playing <= 1'b0;
                  if (final_score > max_score) begin
                     max_score  <= final_score;
                     new_record <= 1'b1;
                  end else begin
                     new_record <= 1'b0;
                  end
               end
            end
            S_OVER: begin
               if (start) begin
                  state      <= S_PLAY;
                  score      <= '0;
                  new_record <= 1'b0;
                  playing    <= 1'b1;
                  blink_cnt  <= '0;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               playing   <= 1'b0;
               blink_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_controller.sv
module tb_score_controller;

   localparam int HP = 1;
   localparam int MV = 99;
   localparam int BB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       hit;
   logic       game_over;
   logic [6:0] score;
   logic [6:0] max_score;
   logic       playing;
   logic       score_blank;
   logic       new_record;

   int checks = 0;
   int errors = 0;

   // Reference model: game state as a small integer, score arithmetic as
   // plain integers, blink derived from the number of cycles spent over.
   int m_state;     // 0 idle, 1 play, 2 over
   int m_score;
   int m_max;
   int m_rec;
   int m_over_cyc;
   bit m_hit_q;

   score_controller #(
      .HIT_POINTS(HP),
      .MAX_VAL   (MV),
      .BLINK_BITS(BB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .hit        (hit),
      .game_over  (game_over),
      .score      (score),
      .max_score  (max_score),
      .playing    (playing),
      .score_blank(score_blank),
      .new_record (new_record)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state    = 0;
      m_score    = 0;
      m_max      = 0;
      m_rec      = 0;
      m_over_cyc = 0;
      m_hit_q    = 1'b1;
   endtask

   task automatic model_step(input bit st, input bit h, input bit go);
      bit rise;
      int s;
      rise    = h && !m_hit_q;
      m_hit_q = h;
      case (m_state)
         0: if (st) begin
               m_state = 1; m_score = 0; m_rec = 0;
            end
         1: begin
               s = m_score;
               if (rise) s = (s + HP > MV) ? MV : s + HP;
               m_score = s;
               if (go) begin
                  m_state    = 2;
                  m_over_cyc = 0;
                  if (s > m_max) begin
                     m_max = s; m_rec = 1;
                  end else begin
                     m_rec = 0;
                  end
               end
            end
         default: begin
               if (st) begin
                  m_state = 1; m_score = 0; m_rec = 0; m_over_cyc = 0;
               end else begin
                  m_over_cyc++;
               end
            end
      endcase
   endtask

   task automatic check_model();
      int exp_blank;
      exp_blank = (m_state == 2) ? ((m_over_cyc / (1 << (BB - 1))) % 2) : 0;
      chk("score",       int'(score),       m_score);
      chk("max_score",   int'(max_score),   m_max);
      chk("playing",     int'(playing),     (m_state == 1) ? 1 : 0);
      chk("score_blank", int'(score_blank), exp_blank);
      chk("new_record",  int'(new_record),  m_rec);
   endtask

   task automatic cycle(input bit st, input bit h, input bit go);
      start     = st;
      hit       = h;
      game_over = go;
      @(posedge clk);
      model_step(st, h, go);
      #1;
      check_model();
   endtask

   task automatic hit_pulse();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      start = 1'b0; hit = 1'b0; game_over = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_score", int'(score), 0);
      chk("arst_max", int'(max_score), 0);
      chk("arst_playing", int'(playing), 0);
      check_model();
      #3;
      rst = 1'b0;
   endtask

   initial begin
      int ones;
      int first_one;
      bit r_st, r_h, r_go;

      rst = 1'b1; start = 1'b0; hit = 1'b1; game_over = 1'b0;
      model_reset();
      #12;
      check_model();
      rst = 1'b0;

      // Start while hit is still held from reset: no hit is counted.
      cycle(1'b1, 1'b1, 1'b0);
      chk("start_playing", int'(playing), 1);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);
      chk("held_hit", int'(score), 0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      chk("first_hit", int'(score), 1);
      cycle(1'b0, 1'b0, 1'b0);

      // Long pulses count once each; two more bring the game to 3.
      repeat (2) begin
         repeat (4) cycle(1'b0, 1'b1, 1'b0);
         cycle(1'b0, 1'b0, 1'b0);
      end
      chk("long_pulses", int'(score), 3);
      cycle(1'b0, 1'b0, 1'b1);
      chk("g1_max", int'(max_score), 3);
      chk("g1_record", int'(new_record), 1);
      chk("g1_playing", int'(playing), 0);

      // Blink: 8 cycles dark-free, then 8 cycles blanked.
      ones = 0; first_one = -1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) cycle(1'b0, 1'b0, 1'b0);
         if (score_blank) begin
            ones++;
            if (first_one < 0) first_one = i;
         end
      end
      chk("blink_ones", ones, 8);
      chk("blink_first", first_one, 8);
      repeat (3) hit_pulse();
      chk("over_hits", int'(score), 3);
      cycle(1'b1, 1'b0, 1'b0);
      chk("restart_score", int'(score), 0);
      chk("restart_blank", int'(score_blank), 0);
      chk("restart_rec", int'(new_record), 0);
      chk("restart_play", int'(playing), 1);

      repeat (2) hit_pulse();
      cycle(1'b0, 1'b0, 1'b1);
      chk("g2_max", int'(max_score), 3);
      chk("g2_record", int'(new_record), 0);

      cycle(1'b1, 1'b0, 1'b0);
      repeat (3) hit_pulse();
      cycle(1'b0, 1'b0, 1'b1);
      chk("tie_max", int'(max_score), 3);
      chk("tie_record", int'(new_record), 0);

      cycle(1'b1, 1'b0, 1'b0);
      repeat (105) hit_pulse();
      chk("sat_score", int'(score), 99);
      repeat (3) hit_pulse();
      chk("sat_hold", int'(score), 99);

      async_reset();

      // Build max_score=40, then hit and game_over on the same edge.
      cycle(1'b1, 1'b0, 1'b0);
      repeat (40) hit_pulse();
      cycle(1'b0, 1'b0, 1'b1);
      chk("g40_max", int'(max_score), 40);
      cycle(1'b1, 1'b0, 1'b0);
      repeat (40) hit_pulse();
      cycle(1'b0, 1'b1, 1'b1);
      chk("same_edge_score", int'(score), 41);
      chk("same_edge_max", int'(max_score), 41);
      chk("same_edge_rec", int'(new_record), 1);

      cycle(1'b1, 1'b0, 1'b0);
      repeat (20) hit_pulse();
      chk("pre_arst_score", int'(score), 20);
      async_reset();
      cycle(1'b0, 1'b1, 1'b1);
      chk("idle_ignore", int'(score), 0);
      cycle(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         r_st = ($urandom_range(0, 24) == 0);
         r_h  = $urandom_range(0, 1) == 1;
         r_go = ($urandom_range(0, 19) == 0);
         cycle(r_st, r_h, r_go);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
